sed_monitor: RTL
================

// Module: sed_monitor
// PURPOSE
//  Schedules and supervises SEDGA soft-error-detection runs.
//  Drives SEDENABLE/SEDSTART/SEDFRCERR and consumes SEDDONE/SEDINPROG/SEDERR.
//  Syncs the SED outputs (SEDCLKOUT domain) into clk, runs periodic or on-demand checks,
//  latches errors and timeouts, and keeps run/error statistics for the controller.
// PARAMETERS
//  INTERVAL    1000000   clk cycles between automatic check starts; 0 = manual (trigger_i) only
//  TIMEOUT     33554432  max clk cycles from start assertion to synced done before abort
//  ERR_WAIT    64        clk cycles after synced done during which sed_err_i is sampled
//  RECOVER_LEN 16        clk cycles sed_enable_o is held low after a timeout
//  CNT_W       16        width of statistics counters
// PORTS
//  clk             in   1      system clock
//  rst             in   1      asynchronous active-high reset
//  en_i            in   1      monitor enable; low forces IDLE, SED disabled
//  trigger_i       in   1      one-cycle request for an immediate check
//  force_err_i     in   1      one-cycle request: inject forced error on next check
//  clr_i           in   1      clear err_o and timeout_o
//  sed_enable_o    out  1      to SEDENABLE
//  sed_start_o     out  1      to SEDSTART
//  sed_frcerr_o    out  1      to SEDFRCERR
//  sed_done_i      in   1      from SEDDONE (async, one SED-clock pulse)
//  sed_inprog_i    in   1      from SEDINPROG (async)
//  sed_err_i       in   1      from SEDERR (async, may lag done)
//  busy_o          out  1      check in progress (START/RUN/SETTLE)
//  err_o           out  1      sticky: SED error seen
//  err_irq_o       out  1      one-cycle pulse per check ending with error
//  timeout_o       out  1      sticky: check aborted on TIMEOUT
//  check_count_o   out  CNT_W  completed checks, saturating
//  err_count_o     out  CNT_W  checks ending with error, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, pending-force clear, both 2-flop syncs cleared.
//  - done/inprog/err each pass a 2-flop sync; done and inprog use rising-edge detect on synced value.
//  - sed_enable_o: registered; 1 whenever en_i=1 and state != RECOVER.
//  - States:
//    - IDLE: en_i=1 -> WAIT_INT, interval counter loaded with INTERVAL-1.
//    - WAIT_INT: counter decrements each cycle. counter==0 (INTERVAL>0) or trigger_i -> START.
//      INTERVAL=0: only trigger_i leaves.
//    - START: sed_start_o=1 and timeout counter runs. Synced inprog rise -> RUN; sed_start_o drops
//      the next cycle. Start is held until the SED clock samples it.
//    - RUN: wait for synced done rise -> SETTLE, ERR_WAIT counter loaded.
//    - SETTLE: OR synced err over ERR_WAIT cycles, then -> WAIT_INT with interval reloaded.
//      Exit cycle: check_count +1; if error, err_count +1, err_o=1, err_irq_o pulses 1 cycle.
//    - Timeout: counter reaches TIMEOUT in START or RUN -> RECOVER, timeout_o=1, sed_start_o=0,
//      no count update.
//    - RECOVER: sed_enable_o=0 for RECOVER_LEN cycles (resets SED FSM), then WAIT_INT.
//  - force_err_i sets pending flag. At entry to START, flag moves to sed_frcerr_o, which stays high
//    through SETTLE and clears at SETTLE exit or abort. A request during a check applies to the next one.
//  - trigger_i outside WAIT_INT is ignored; no queuing.
//  - en_i low in any state: next cycle IDLE, start/frcerr/enable=0.
//    Sticky flags and counters retained; pending force cleared.
//  - clr_i and a new error/timeout in the same cycle: set wins, flag stays 1.
//  - Counters saturate at all-ones; only rst clears them.
// TESTING
//  - INTERVAL=100, SEDGA model, en_i=1 -> start asserted ~100 cycles after enable; one done per check;
//    check_count_o=1 after first SETTLE; err_o=0.
//  - force_err_i pulse before check -> sed_frcerr_o high during that check; err_o=1; err_irq_o one cycle;
//    err_count_o=1; next check clean, err_count_o stays 1.
//  - Stub SED never asserts inprog, TIMEOUT=500 -> timeout_o=1 at 500 cycles;
//    sed_enable_o low 16 cycles; FSM back in WAIT_INT.
//  - INTERVAL=0, trigger_i pulses in WAIT_INT and during RUN -> only the WAIT_INT pulse starts a check.
//  - en_i dropped during RUN -> IDLE next cycle, sed_enable_o=0, counters unchanged;
//    rst mid-check -> all outputs 0.
//  - clr_i asserted in the cycle err_o would set -> err_o=1. CNT_W=2 with 5 checks -> check_count_o=3.

Source files
------------

// File: rtl/sed_monitor.sv
// Schedules SED checks (periodic or triggered), syncs SEDDONE/SEDINPROG/SEDERR and supervises timeouts.
// Outputs registered; start held until the SED acknowledges with inprog; triggers outside WAIT_INT dropped.
module sed_monitor #(
  parameter int unsigned INTERVAL    = 1000000,
  parameter int unsigned TIMEOUT     = 33554432,
  parameter int unsigned ERR_WAIT    = 64,
  parameter int unsigned RECOVER_LEN = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             trigger_i,
  input  logic             force_err_i,
  input  logic             clr_i,
  output logic             sed_enable_o,
  output logic             sed_start_o,
  output logic             sed_frcerr_o,
  input  logic             sed_done_i,
  input  logic             sed_inprog_i,
  input  logic             sed_err_i,
  output logic             busy_o,
  output logic             err_o,
  output logic             err_irq_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] check_count_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam logic [31:0] INT_LOAD = (INTERVAL == 0)    ? 32'd0 : 32'(INTERVAL - 1);
  localparam logic [31:0] TMO_LAST = (TIMEOUT == 0)     ? 32'd0 : 32'(TIMEOUT - 1);
  localparam logic [31:0] ERR_LOAD = (ERR_WAIT == 0)    ? 32'd0 : 32'(ERR_WAIT - 1);
  localparam logic [31:0] REC_LOAD = (RECOVER_LEN == 0) ? 32'd0 : 32'(RECOVER_LEN - 1);
  localparam logic        AUTO_RUN = (INTERVAL != 0);

  typedef enum logic [2:0] {IDLE, WAIT_INT, START, RUN, SETTLE, RECOVER} state_t;

  state_t      state;
  logic [31:0] int_cnt;
  logic [31:0] tmo_cnt;
  logic [31:0] aux_cnt;
  logic        err_acc;
  logic        force_pend;

  logic done_s1, done_s2, done_d;
  logic inp_s1, inp_s2, inp_d;
  logic err_s1, err_s2;
  logic done_rise, inp_rise, err_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_d  <= 1'b0;
      inp_s1  <= 1'b0;
      inp_s2  <= 1'b0;
      inp_d   <= 1'b0;
      err_s1  <= 1'b0;
      err_s2  <= 1'b0;
    end else begin
      done_s1 <= sed_done_i;
      done_s2 <= done_s1;
      done_d  <= done_s2;
      inp_s1  <= sed_inprog_i;
      inp_s2  <= inp_s1;
      inp_d   <= inp_s2;
      err_s1  <= sed_err_i;
      err_s2  <= err_s1;
    end
  end

  assign done_rise = done_s2 & ~done_d;
  assign inp_rise  = inp_s2 & ~inp_d;
  assign err_seen  = err_acc | err_s2;
  assign busy_o    = (state == START) || (state == RUN) || (state == SETTLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      int_cnt       <= '0;
      tmo_cnt       <= '0;
      aux_cnt       <= '0;
      err_acc       <= 1'b0;
      force_pend    <= 1'b0;
      sed_enable_o  <= 1'b0;
      sed_start_o   <= 1'b0;
      sed_frcerr_o  <= 1'b0;
      err_o         <= 1'b0;
      err_irq_o     <= 1'b0;
      timeout_o     <= 1'b0;
      check_count_o <= '0;
      err_count_o   <= '0;
    end else begin
      err_irq_o <= 1'b0;
      // Clear is applied first so a same-cycle set below takes precedence.
      if (clr_i) begin
        err_o     <= 1'b0;
        timeout_o <= 1'b0;
      end
      if (!en_i) begin
        state        <= IDLE;
        sed_enable_o <= 1'b0;
        sed_start_o  <= 1'b0;
        sed_frcerr_o <= 1'b0;
        force_pend   <= 1'b0;
      end else begin
        sed_enable_o <= 1'b1;
        if (force_err_i) force_pend <= 1'b1;
        unique case (state)
          IDLE: begin
            state   <= WAIT_INT;
            int_cnt <= INT_LOAD;
          end
          WAIT_INT: begin
            if (trigger_i || (AUTO_RUN && int_cnt == 32'd0)) begin
              state        <= START;
              sed_start_o  <= 1'b1;
              sed_frcerr_o <= force_pend | force_err_i;
              force_pend   <= 1'b0;
              tmo_cnt      <= '0;
            end else if (int_cnt != 32'd0) begin
              int_cnt <= int_cnt - 32'd1;
            end
          end
          START, RUN: begin
            if (tmo_cnt == TMO_LAST) begin
              state        <= RECOVER;
              timeout_o    <= 1'b1;
              sed_start_o  <= 1'b0;
              sed_frcerr_o <= 1'b0;
              sed_enable_o <= 1'b0;
              aux_cnt      <= REC_LOAD;
            end else begin
              tmo_cnt <= tmo_cnt + 32'd1;
              if (state == START && inp_rise) begin
                state       <= RUN;
                sed_start_o <= 1'b0;
              end else if (state == RUN && done_rise) begin
                state   <= SETTLE;
                aux_cnt <= ERR_LOAD;
                err_acc <= 1'b0;
              end
            end
          end
          SETTLE: begin
            if (aux_cnt == 32'd0) begin
              state        <= WAIT_INT;
              int_cnt      <= INT_LOAD;
              sed_frcerr_o <= 1'b0;
              if (check_count_o != '1) check_count_o <= check_count_o + 1'b1;
              if (err_seen) begin
                err_o     <= 1'b1;
                err_irq_o <= 1'b1;
                if (err_count_o != '1) err_count_o <= err_count_o + 1'b1;
              end
            end else begin
              aux_cnt <= aux_cnt - 32'd1;
              err_acc <= err_seen;
            end
          end
          RECOVER: begin
            // Enable stays low long enough to reset the SED's internal FSM.
            if (aux_cnt == 32'd0) begin
              state   <= WAIT_INT;
              int_cnt <= INT_LOAD;
            end else begin
              sed_enable_o <= 1'b0;
              aux_cnt      <= aux_cnt - 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
